// File: rtl/avalon_copy_master.sv
// Avalon-MM copy initiator: moves len_i 32-bit words from src_addr_i to
// dst_addr_i, one read followed by one write per word, fixed read latency.
module avalon_copy_master #(
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             aborted_o,
    output logic [LEN_W-1:0] count_o,
    output logic [31:0]      avalon_addr_o,
    output logic             avalon_read_o,
    output logic             avalon_write_o,
    output logic [31:0]      avalon_writedata_o,
    output logic [3:0]       avalon_byteenable_o,
    input  logic             avalon_waitrequest_i,
    input  logic [31:0]      avalon_readdata_i
);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]       state_q;
    logic [31:0]      src_q, dst_q, data_q;
    logic [LEN_W-1:0] len_q, count_q;
    logic [LAT_W-1:0] lat_q;
    logic             err_q, abort_q;
    logic [LEN_W-1:0] count_nxt;
    logic             misaligned;

    assign count_nxt  = count_q + LEN_W'(1);
    assign misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);

    // Copy sequencer: latch job, alternate read/write per word, finish in DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            // Abort is only remembered here; it takes effect at the word boundary.
            if (abort_i && state_q != S_IDLE && state_q != S_DONE)
                abort_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    abort_q <= 1'b0;
                    if (start_i) begin
                        src_q   <= src_addr_i;
                        dst_q   <= dst_addr_i;
                        len_q   <= len_i;
                        count_q <= '0;
                        err_q   <= misaligned;
                        if (misaligned || len_i == '0) state_q <= S_DONE;
                        else                           state_q <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (!avalon_waitrequest_i) begin
                        lat_q   <= LAT_W'(RD_LAT);
                        state_q <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (lat_q <= LAT_W'(1)) begin
                        data_q  <= avalon_readdata_i;
                        state_q <= S_WR_REQ;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                S_WR_REQ: begin
                    if (!avalon_waitrequest_i) begin
                        count_q <= count_nxt;
                        src_q   <= src_q + 32'd4;
                        dst_q   <= dst_q + 32'd4;
                        // Abort seen on this very edge still ends the copy here.
                        if (count_nxt == len_q || abort_q || abort_i) state_q <= S_DONE;
                        else                                          state_q <= S_RD_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Bus and status outputs decode straight from state so reset clears them at once.
    always_comb begin
        avalon_read_o       = (state_q == S_RD_REQ);
        avalon_write_o      = (state_q == S_WR_REQ);
        avalon_addr_o       = avalon_read_o ? src_q : (avalon_write_o ? dst_q : 32'd0);
        avalon_writedata_o  = avalon_write_o ? data_q : 32'd0;
        avalon_byteenable_o = (avalon_read_o || avalon_write_o) ? 4'hF : 4'h0;
        busy_o              = (state_q != S_IDLE);
        done_o              = (state_q == S_DONE);
        err_o               = done_o && err_q;
        aborted_o           = done_o && abort_q;
        count_o             = count_q;
    end
endmodule

// File: tb/tb_avalon_copy_master.sv
module tb_avalon_copy_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, abort;
    logic [31:0] src, dst;
    logic [15:0] len;
    logic        busy, done, err, aborted;
    logic [15:0] count;
    logic [31:0] addr, wdata, rdata;
    logic        rd, wr, waitreq;
    logic [3:0]  be;
    logic [31:0] rd_addr_q;

    int checks = 0;
    int failures = 0;

    avalon_copy_master #(.LEN_W(16), .RD_LAT(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
        .busy_o(busy), .done_o(done), .err_o(err), .aborted_o(aborted), .count_o(count),
        .avalon_addr_o(addr), .avalon_read_o(rd), .avalon_write_o(wr),
        .avalon_writedata_o(wdata), .avalon_byteenable_o(be),
        .avalon_waitrequest_i(waitreq), .avalon_readdata_i(rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Slave model: one-cycle registered read data.
    always @(posedge clk) if (rd && !waitreq) rd_addr_q <= addr;
    assign rdata = pat(rd_addr_q);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ab_mode: 0 none, 1 abort pulse in RD_WAIT after read ab_word, 2 abort with write of word ab_word
    typedef struct {
        string       name;
        logic [31:0] src, dst;
        logic [15:0] len;
        int          rd_st, wr_st, ab_mode, ab_word, spur;
        int          exp_cnt, exp_err, exp_ab, exp_edges;
    } vec_t;

    task automatic run_copy(input vec_t v);
        int rd_i = 0, wr_i = 0, edges = 0, rd_left = v.rd_st, wr_left = v.wr_st;
        bit ab_sent = 0, seen = 0;
        start = 1'b1; src = v.src; dst = v.dst; len = v.len;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) begin seen = 1; break; end
            chk({v.name, " busy"}, busy, 1);
            if (rd && wr) chk({v.name, " rd_wr_excl"}, 1, 0);
            abort = 1'b0;
            start = (cyc == v.spur);
            len   = (cyc == v.spur) ? v.len + 16'd5 : v.len;
            if (rd) begin
                chk({v.name, " rd_addr"}, addr, v.src + 32'(4 * rd_i));
                chk({v.name, " rd_be"}, be, 4'hF);
                if (rd_left > 0) begin waitreq = 1'b1; rd_left--; end
                else begin waitreq = 1'b0; rd_i++; end
            end else if (wr) begin
                chk({v.name, " wr_addr"}, addr, v.dst + 32'(4 * wr_i));
                chk({v.name, " wr_data"}, wdata, pat(v.src + 32'(4 * wr_i)));
                chk({v.name, " wr_be"}, be, 4'hF);
                if (wr_left > 0) begin waitreq = 1'b1; wr_left--; end
                else begin
                    waitreq = 1'b0; wr_i++;
                    if (v.ab_mode == 2 && wr_i == v.ab_word) abort = 1'b1;
                end
            end else begin
                waitreq = 1'b0;
                chk({v.name, " idle_be"}, be, 0);
                if (v.ab_mode == 1 && !ab_sent && rd_i == v.ab_word) begin
                    abort = 1'b1; ab_sent = 1;
                end
            end
            @(posedge clk); #1;
            edges++;
        end
        abort = 1'b0; start = 1'b0; waitreq = 1'b0;
        if (!seen) chk({v.name, " timeout"}, 0, 1);
        chk({v.name, " latency"}, edges, v.exp_edges);
        chk({v.name, " err"}, err, v.exp_err);
        chk({v.name, " aborted"}, aborted, v.exp_ab);
        chk({v.name, " count"}, count, v.exp_cnt);
        chk({v.name, " reads"}, rd_i, v.exp_cnt);
        chk({v.name, " writes"}, wr_i, v.exp_cnt);
        @(posedge clk); #1;
        chk({v.name, " done_pulse"}, done, 0);
        chk({v.name, " idle"}, busy, 0);
        @(posedge clk); #1;
        chk({v.name, " count_hold"}, count, v.exp_cnt);
        chk({v.name, " no_bus"}, {rd, wr}, 0);
    endtask

    vec_t tbl[6];

    initial begin
        start = 0; abort = 0; src = 0; dst = 0; len = 0; waitreq = 0;
        tbl[0] = '{"T1",  32'h10000, 32'h10100, 16'd4, 0, 0, 0, 0, -1, 4, 0, 0, 12};
        tbl[1] = '{"T2",  32'h20000, 32'h20400, 16'd1, 3, 2, 0, 0, -1, 1, 0, 0, 8};
        tbl[2] = '{"T3",  32'h10002, 32'h10100, 16'd4, 0, 0, 0, 0, -1, 0, 1, 0, 0};
        tbl[3] = '{"T4",  32'h10000, 32'h10100, 16'd0, 0, 0, 0, 0, -1, 0, 0, 0, 0};
        tbl[4] = '{"T5",  32'h30000, 32'h31000, 16'd8, 0, 0, 1, 3, -1, 3, 0, 1, 9};
        tbl[5] = '{"SIM", 32'hFFFF_FFF8, 32'h40000, 16'd2, 0, 0, 2, 2, -1, 2, 0, 1, 6};

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bus", {rd, wr, be}, 0);
        chk("rst_count", count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) run_copy(tbl[i]);

        // Reset asserted while a write is stalled: everything drops immediately.
        start = 1; src = 32'h200; dst = 32'h300; len = 16'd2;
        @(posedge clk); #1;
        start = 0;
        for (int c = 0; c < 20 && !wr; c++) begin @(posedge clk); #1; end
        chk("T6 in_write", wr, 1);
        waitreq = 1'b1;
        @(posedge clk); #1;
        chk("T6 wr_held", {wr, addr}, {1'b1, 32'h300});
        #2 rst_n = 1'b0;
        #1;
        chk("T6 rst_bus", {rd, wr, addr, wdata, be}, 0);
        chk("T6 rst_stat", {busy, done, err, aborted}, 0);
        chk("T6 rst_count", count, 0);
        waitreq = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("T6 idle", busy, 0);
        run_copy('{"T6b", 32'h500, 32'h600, 16'd3, 0, 0, 0, 0, 2, 3, 0, 0, 9});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
